// File: rtl/forward_net_sequencer.sv
// forward_net_sequencer
//   Sequences one cost pass over n_samples samples through a forward network
//   with fixed latency LAT. For each sample it issues a load, waits for the
//   network/loss pipeline, then adds the sum of all L4 squared-error lanes
//   into the cost accumulator.
//
// Ports
//   clk, reset       clock (rising edge), asynchronous active-low reset
//   start, abort     begin a pass (IDLE only) / cancel the pass in progress
//   n_samples        sample count, latched when start is accepted
//   in_valid         source presents sample sample_idx
//   in_ready         sequencer accepts a sample this cycle
//   err_flat         L4 lanes of DW-bit squared error, lane k at [k*DW +: DW]
//   load             network captures the current sample
//   net_clear        clears network pipeline state at the start of a pass
//   acc_en           err_flat is accumulated this cycle
//   sample_idx       index of the sample being requested or processed
//   cost, overflow   accumulated cost and sticky overflow flag
//   busy, done       not idle / one-cycle pass completion pulse
//
// Configuration
//   FORWARD_NET_COST_SATURATE_EN  defined: cost clamps at 2^ACCW-1 on overflow.
//                                 undefined: cost wraps modulo 2^ACCW.

// One lane of the error adder chain: zero-extends the lane and adds it.
module fns_lane_add #(
  parameter int DW = 16,
  parameter int SW = 34
) (
  input  logic [DW-1:0] lane,
  input  logic [SW-1:0] part,
  output logic [SW-1:0] total
);
  assign total = part + SW'(lane);
endmodule

module forward_net_sequencer #(
  parameter int L4   = 2,
  parameter int DW   = 16,
  parameter int ACCW = 32,
  parameter int LAT  = 3,
  parameter int NW   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [NW-1:0]      n_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [L4*DW-1:0]   err_flat,
  output logic               load,
  output logic               net_clear,
  output logic               acc_en,
  output logic [NW-1:0]      sample_idx,
  output logic [ACCW-1:0]    cost,
  output logic               overflow,
  output logic               busy,
  output logic               done
);
  // Sum width keeps one carry beyond the accumulator even with many lanes.
  localparam int SW      = ACCW + $clog2(L4) + 1;
  localparam int CW      = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int WAIT_IV = (LAT >= 2) ? LAT - 2 : 0;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ISSUE, S_WAIT, S_ACCUM, S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [NW-1:0]   n_lat;
  logic            last;
  logic            abort_act;

  // ---------------- lane adder chain ----------------
  logic [L4-1:0][DW-1:0] lanes;
  logic [SW-1:0]         psum [L4+1];

  assign lanes   = err_flat;
  assign psum[0] = '0;

  for (genvar k = 0; k < L4; k++) begin : g_lane
    fns_lane_add #(.DW(DW), .SW(SW)) u_add (
      .lane  (lanes[k]),
      .part  (psum[k]),
      .total (psum[k+1])
    );
  end

  logic [SW-1:0]   cost_sum;
  logic            sum_ovf;
  logic [ACCW-1:0] cost_nxt;

  assign cost_sum = SW'(cost) + psum[L4];
  assign sum_ovf  = |cost_sum[SW-1:ACCW];

`ifdef FORWARD_NET_COST_SATURATE_EN
  // Once clamped, any further addition overflows again, so cost stays pinned.
  assign cost_nxt = sum_ovf ? {ACCW{1'b1}} : cost_sum[ACCW-1:0];
`else
  assign cost_nxt = cost_sum[ACCW-1:0];
`endif

  // ---------------- control ----------------
  assign last      = (sample_idx == (n_lat - NW'(1)));
  assign abort_act = abort && (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    load      = 1'b0;
    net_clear = 1'b0;
    acc_en    = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = (n_samples != '0) ? S_CLEAR : S_DONE;
      S_CLEAR: begin
        net_clear = 1'b1;
        state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        in_ready = 1'b1;
        load     = in_valid;
        if (in_valid) state_nxt = (LAT == 1) ? S_ACCUM : S_WAIT;
      end
      S_WAIT:  if (cnt == '0) state_nxt = S_ACCUM;
      S_ACCUM: begin
        acc_en    = 1'b1;
        state_nxt = last ? S_DONE : S_ISSUE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Abort overrides any handshake or accumulate in the same cycle.
    if (abort_act) begin
      in_ready  = 1'b0;
      load      = 1'b0;
      acc_en    = 1'b0;
      state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      n_lat      <= '0;
      sample_idx <= '0;
      cost       <= '0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);
      done  <= (state_nxt == S_DONE);

      if (state == S_IDLE && start) begin
        n_lat <= n_samples;
        // Empty pass reports a zero cost straight away.
        if (n_samples == '0) begin
          cost       <= '0;
          overflow   <= 1'b0;
          sample_idx <= '0;
        end
      end

      if (state == S_CLEAR && !abort_act) begin
        cost       <= '0;
        overflow   <= 1'b0;
        sample_idx <= '0;
      end

      // WAIT lasts LAT-1 cycles: counter starts at LAT-2 and exits at zero.
      if (load)
        cnt <= CW'(WAIT_IV);
      else if (state == S_WAIT && cnt != '0)
        cnt <= cnt - CW'(1);

      if (acc_en) begin
        cost     <= cost_nxt;
        overflow <= overflow | sum_ovf;
        if (!last) sample_idx <= sample_idx + NW'(1);
      end
    end
  end

endmodule

// File: tb/tb_forward_net_sequencer.sv
module tb_forward_net_sequencer;
  localparam int L4 = 2, DW = 16, ACCW = 32, LAT = 3, NW = 8;

  logic clk = 1'b0, reset = 1'b0;
  logic start = 1'b0, abort = 1'b0, in_valid = 1'b0;
  logic [NW-1:0] n_samples = '0;
  logic [L4*DW-1:0] err_flat = '0;
  logic in_ready, load, net_clear, acc_en, overflow, busy, done;
  logic [NW-1:0] sample_idx;
  logic [ACCW-1:0] cost;

  logic start17 = 1'b0, abort17 = 1'b0, in_valid17 = 1'b0;
  logic [NW-1:0] n17 = '0;
  logic [L4*DW-1:0] err17 = '0;
  logic in_ready17, load17, net_clear17, acc_en17, overflow17, busy17, done17;
  logic [NW-1:0] sample_idx17;
  logic [16:0] cost17;

  forward_net_sequencer #(.L4(L4), .DW(DW), .ACCW(ACCW), .LAT(LAT), .NW(NW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(in_ready), .err_flat(err_flat), .load(load),
    .net_clear(net_clear), .acc_en(acc_en), .sample_idx(sample_idx), .cost(cost),
    .overflow(overflow), .busy(busy), .done(done));

  forward_net_sequencer #(.L4(L4), .DW(DW), .ACCW(17), .LAT(LAT), .NW(NW)) dut17 (
    .clk(clk), .reset(reset), .start(start17), .abort(abort17), .n_samples(n17),
    .in_valid(in_valid17), .in_ready(in_ready17), .err_flat(err17), .load(load17),
    .net_clear(net_clear17), .acc_en(acc_en17), .sample_idx(sample_idx17), .cost(cost17),
    .overflow(overflow17), .busy(busy17), .done(done17));

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  logic [L4*DW-1:0] smp [64];

  typedef struct {
    int          n;
    logic [15:0] l0;
    logic [15:0] l1;
    longint      cost;
    bit          ovf;
  } vec_t;
  vec_t vt [6];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  // Reference: total of every lane of every sample, then wrapped or clamped.
  function automatic longint model_cost(input int n, input int aw, output bit ovf);
    longint tot = 0;
    longint lim = (longint'(1) << aw) - 1;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < L4; k++)
        tot += longint'(smp[i][k*DW +: DW]);
    ovf = (tot > lim);
`ifdef FORWARD_NET_COST_SATURATE_EN
    return ovf ? lim : tot;
`else
    return tot & lim;
`endif
  endfunction

  // One full pass; the bench presents the sample's lanes only in the cycle
  // LAT after its load, with noise elsewhere.
  task automatic run_pass(input string tag, input int n, input bit gaps, input bit noise,
                          input longint ec, input bit eo);
    int loads = 0, accs = 0, clears = 0, load_c = -100;
    bit fin = 0;
    for (int c = 0; c < 400 && !fin; c++) begin
      tick();
      reset     = 1'b1;
      start     = (c == 0) ? 1'b1 : (noise && ($urandom_range(0, 7) == 0));
      n_samples = (c == 0) ? NW'(n) : NW'($urandom);
      in_valid  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      err_flat  = (c == load_c + LAT) ? smp[accs] : $urandom;
      samp();
      if (net_clear) clears++;
      chk({tag, " load_hs"}, load, in_valid & in_ready);
      if (load) begin
        if (!gaps) chk({tag, " load_cyc"}, c, 2 + loads * (LAT + 1));
        load_c = c;
        loads++;
      end
      if (acc_en) begin
        chk({tag, " acc_cyc"}, c, load_c + LAT);
        chk({tag, " idx"}, sample_idx, accs);
        accs++;
      end
      if (done) begin
        fin = 1;
        if (!gaps) chk({tag, " done_cyc"}, c, (n == 0) ? 1 : 2 + n * (LAT + 1));
        chk({tag, " cost"}, cost, ec);
        chk({tag, " ovf"}, overflow, eo);
        chk({tag, " loads"}, loads, n);
        chk({tag, " clears"}, clears, (n != 0) ? 1 : 0);
        chk({tag, " busy_done"}, busy, 1);
      end
    end
    start = 1'b0;
    if (!fin) chk({tag, " timeout"}, 0, 1);
    tick();
    samp();
    chk({tag, " idle_busy"}, busy, 0);
    chk({tag, " idle_done"}, done, 0);
    chk({tag, " hold_cost"}, cost, ec);
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      samp();
      if (done) seen = 1;
    end
    chk({tag, " done_seen"}, seen, 1);
  endtask

  initial begin
    longint ec;
    bit eo;
    int accs;
    bit prev_acc;

    vt[0] = '{3, 16'd1,     16'd2,     64'd9,       1'b0};
    vt[1] = '{0, 16'd7,     16'd7,     64'd0,       1'b0};
    vt[2] = '{1, 16'hFFFF,  16'hFFFF,  64'h1FFFE,   1'b0};
    vt[3] = '{4, 16'd10,    16'd20,    64'd120,     1'b0};
    vt[4] = '{5, 16'd0,     16'd0,     64'd0,       1'b0};
    vt[5] = '{2, 16'h8000,  16'h0001,  64'h10002,   1'b0};

    // Reset state
    repeat (3) tick();
    samp();
    chk("rst cost", cost, 0);
    chk("rst busy", busy, 0);
    chk("rst in_ready", in_ready, 0);
    chk("rst net_clear", net_clear, 0);
    chk("rst sample_idx", sample_idx, 0);

    // Table-driven passes (first one also releases reset with start)
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < vt[v].n; i++) smp[i] = {vt[v].l1, vt[v].l0};
      run_pass($sformatf("vec%0d", v), vt[v].n, 1'b0, 1'b1, vt[v].cost, vt[v].ovf);
    end

    // in_valid low while in ISSUE
    err_flat = {16'd0, 16'd5};
    tick(); start = 1'b1; n_samples = 8'd1; in_valid = 1'b0; samp();
    tick(); start = 1'b0; samp();
    chk("stall net_clear", net_clear, 1);
    for (int i = 0; i < 5; i++) begin
      tick(); in_valid = 1'b0; samp();
      chk("stall in_ready", in_ready, 1);
      chk("stall load", load, 0);
    end
    tick(); in_valid = 1'b1; samp();
    chk("stall load_go", load, 1);
    wait_done("stall", 10);
    chk("stall cost", cost, 5);

    // start ignored in WAIT, then abort in WAIT
    err_flat = {16'd2, 16'd1};
    tick(); start = 1'b1; n_samples = 8'd3; in_valid = 1'b1; samp();
    tick(); start = 1'b0; samp();
    for (int i = 0; i < 4; i++) begin tick(); samp(); end
    chk("abw acc", acc_en, 1);
    tick(); samp();
    chk("abw load2", load, 1);
    chk("abw cost1", cost, 3);
    tick(); start = 1'b1; n_samples = 8'd0; samp();
    tick(); start = 1'b0; abort = 1'b1; samp();
    chk("abw busy", busy, 1);
    chk("abw nodone", done, 0);
    chk("abw cost_keep", cost, 3);
    tick(); abort = 1'b0; samp();
    chk("abw idle", busy, 0);
    chk("abw cost_hold", cost, 3);
    for (int i = 0; i < 3; i++) begin
      tick(); samp();
      chk("abw no_done", done, 0);
    end

    // abort against a handshake in ISSUE
    tick(); start = 1'b1; n_samples = 8'd2; samp();
    tick(); start = 1'b0; samp();
    tick(); abort = 1'b1; samp();
    chk("abi in_ready", in_ready, 0);
    chk("abi load", load, 0);
    tick(); abort = 1'b0; samp();
    chk("abi busy", busy, 0);
    chk("abi cost", cost, 0);

    // abort against ACCUM: partial cost must not include this sample
    tick(); start = 1'b1; n_samples = 8'd1; samp();
    tick(); start = 1'b0; samp();
    for (int i = 0; i < 3; i++) begin tick(); samp(); end
    tick(); abort = 1'b1; samp();
    tick(); abort = 1'b0; samp();
    chk("aba cost", cost, 0);
    chk("aba busy", busy, 0);
    chk("aba done", done, 0);

    // asynchronous reset during the second ACCUM
    tick(); start = 1'b1; n_samples = 8'd2; samp();
    tick(); start = 1'b0; samp();
    for (int i = 0; i < 8; i++) begin tick(); samp(); end
    chk("rma acc", acc_en, 1);
    chk("rma cost_pre", cost, 3);
    #1 reset = 1'b0;
    #1;
    chk("rma acc_en", acc_en, 0);
    chk("rma cost", cost, 0);
    chk("rma busy", busy, 0);
    chk("rma idx", sample_idx, 0);
    chk("rma outs", {in_ready, load, net_clear, done, overflow}, 0);
    for (int i = 0; i < 3; i++) smp[i] = {16'd2, 16'd1};
    run_pass("post_rst", 3, 1'b0, 1'b0, 64'd9, 1'b0);

    // 17-bit accumulator overflow
    err17 = {16'hFFFF, 16'hFFFF};
    in_valid17 = 1'b1;
    tick(); start17 = 1'b1; n17 = 8'd2; samp();
    tick(); start17 = 1'b0; samp();
    accs = 0;
    prev_acc = 0;
    for (int i = 0; i < 30 && !done17; i++) begin
      tick(); samp();
      if (prev_acc && accs == 1) begin
        chk("a17 cost1", cost17, 64'h1FFFE);
        chk("a17 ovf1", overflow17, 0);
      end
      prev_acc = acc_en17;
      if (acc_en17) accs++;
    end
    chk("a17 done", done17, 1);
`ifdef FORWARD_NET_COST_SATURATE_EN
    chk("a17 cost2", cost17, 64'h1FFFF);
`else
    chk("a17 cost2", cost17, 64'h1FFFC);
`endif
    chk("a17 ovf2", overflow17, 1);
    in_valid17 = 1'b0;

    // Randomized passes against the reference model
    for (int r = 0; r < 12; r++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++)
        smp[i] = (r % 3 == 0) ? {16'hFFFF, 16'(~$urandom_range(0, 255))} : $urandom;
      ec = model_cost(n, ACCW, eo);
      run_pass($sformatf("rnd%0d", r), n, 1'b1, 1'b1, ec, eo);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/forward_net_sequencer.md
FORWARD_NET_SEQUENCER -- requirements
Module: forward_net_sequencer

Interface
REQ-001 Param L4, default 2, number of network outputs (error lanes).
REQ-002 Param DW, default 16, width of one squared-error lane, unsigned.
REQ-003 Param ACCW, default 32, cost accumulator width; ACCW >= DW+1.
REQ-004 Param LAT, default 3, forward-network latency in cycles from load to valid error; LAT >= 1.
REQ-005 Param NW, default 8, sample-count/index width.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  begin one cost pass; sampled only in IDLE.
REQ-009 abort  in  1  synchronous cancel of the pass in progress.
REQ-010 n_samples  in  NW  samples in the pass; latched on accepted start.
REQ-011 in_valid  in  1  source presents sample sample_idx (a1, y).
REQ-012 in_ready  out  1  sequencer can accept a sample.
REQ-013 err_flat  in  L4*DW  per-lane squared error from the loss stage; lane k at bits [k*DW +: DW].
REQ-014 load  out  1  one-cycle pulse; network captures the current sample.
REQ-015 net_clear  out  1  one-cycle pulse clearing network pipeline state.
REQ-016 acc_en  out  1  high in the cycle err_flat is accumulated.
REQ-017 sample_idx  out  NW  index of the sample being requested or processed.
REQ-018 cost  out  ACCW  accumulated cost of the pass.
REQ-019 overflow  out  1  sticky; cost exceeded 2^ACCW-1 during the pass.
REQ-020 busy  out  1  high in every state except IDLE.
REQ-021 done  out  1  one-cycle pulse at pass completion.

Function
REQ-022 FSM states IDLE, CLEAR, ISSUE, WAIT, ACCUM, DONE; state and outputs registered except in_ready/load/net_clear/acc_en, which decode from state.
REQ-023 IDLE: start=1, n_samples!=0 -> CLEAR, latch n_samples; start=1, n_samples=0 -> DONE, cost=0; else stay.
REQ-024 CLEAR (1 cycle): net_clear=1; cost, overflow, sample_idx cleared at the following edge; -> ISSUE.
REQ-025 ISSUE: in_ready=1; load = in_valid & in_ready; on load -> WAIT, latency counter = LAT-2 (LAT=1: -> ACCUM directly; LAT=2: WAIT lasts 1 cycle).
REQ-026 WAIT: holds LAT-1 cycles total, then -> ACCUM; ACCUM cycle is exactly LAT cycles after the load cycle.
REQ-027 ACCUM (1 cycle): acc_en=1; cost += zero-extended sum of all L4 lanes; if sample_idx == latched n-1 -> DONE, else sample_idx+1 and -> ISSUE.
REQ-028 Per-sample period is LAT+1 cycles with in_valid held high; no sample overlap.
REQ-029 DONE (1 cycle): done=1; -> IDLE; cost, overflow, sample_idx hold until next CLEAR.
REQ-030 start while busy is ignored; n_samples changes while busy are ignored.
REQ-031 abort=1 in any non-IDLE state: in_ready and load forced 0 that cycle, -> IDLE next edge, done not pulsed, cost holds its partial value; abort wins over a simultaneous handshake or ACCUM update.
REQ-032 in_valid low in ISSUE: remain in ISSUE indefinitely, no load.

Reset
REQ-033 reset low asynchronously forces IDLE, and cost=0, overflow=0, sample_idx=0, busy=0, done=0, in_ready=0, load=0, net_clear=0, acc_en=0, including mid-pass.
REQ-034 First start is accepted at the first rising edge after reset deasserts.

Configuration
REQ-035 Macro FORWARD_NET_COST_SATURATE_EN defined: on overflow, cost clamps to 2^ACCW-1 and stays there for the pass; overflow=1.
REQ-036 Macro undefined: cost wraps modulo 2^ACCW; overflow=1 sticky.

Verification (L4=2, DW=16, LAT=3, NW=8, ACCW=32 unless stated)
REQ-037 start, n=3, in_valid=1, err lanes {1,2}: start accepted at cycle 0 -> CLEAR cycle 1, load cycles 2/6/10, acc_en cycles 5/9/13, done cycle 14, cost=9, sample_idx 0,1,2.
REQ-038 start, n=0 -> done on the next cycle, cost=0, no load or net_clear pulses.
REQ-039 in_valid low for 5 cycles in ISSUE -> in_ready=1 throughout, no load; load on the first cycle in_valid=1.
REQ-040 ACCW=17, n=2, lanes {0xFFFF,0xFFFF}: cost 0x1FFFE after sample 0; after sample 1 -> 0x1FFFC, overflow=1 (macro undefined) or 0x1FFFF, overflow=1 (macro defined).
REQ-041 start pulsed during WAIT ignored; abort in WAIT -> IDLE next cycle, busy=0, no done, cost holds its partial value.
REQ-042 reset low mid-ACCUM -> all outputs 0 immediately without a clock edge; after release, a new pass runs as in REQ-037.
